nibble_core_p: RTL and testbench

- Parametrised, multi-cycle accumulator processor core; next generation of the fixed 8-bit/5-bit nibble processor.
- Fetches instructions from an external synchronous ROM, executes ALU, memory, branch and halt operations, and holds an internal data RAM.
- Adds three things the fixed core lacks: run/stall control, conditional and unconditional jumps, and a sticky HALT state.
- Sits at the top of the processor datapath. Debug outputs feed the board display/LEDs.

---
 rtl/nibble_core_p.sv | 169 ++++++++++++++++
 tb/tb_nibble_core_p.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_core_p.sv
// Multi-cycle accumulator core: FETCH/LOAD/EXEC/WB/HALT over an external synchronous ROM.
// Optional retired-instruction counter is enabled by defining NIBBLE_RETIRE_COUNT_EN.
module nibble_core_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PC_W = 5,
  localparam int unsigned INSTR_W = 3 + ADDR_W + 2 * DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_addr,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         op,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  x,
  output logic [DATA_W-1:0]  y,
  output logic [DATA_W-1:0]  r,
  output logic               zero,
  output logic               halted
`ifdef NIBBLE_RETIRE_COUNT_EN
  ,
  output logic [15:0]        retired
`endif
);

  localparam logic [2:0] OpStore = 3'b100;
  localparam logic [2:0] OpJz    = 3'b101;
  localparam logic [2:0] OpJmp   = 3'b110;
  localparam logic [2:0] OpHalt  = 3'b111;

  typedef enum logic [2:0] {StFetch, StLoad, StExec, StWb, StHalt} state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] alu_res;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (run) state_d = StLoad;
      StLoad:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = (op_q == OpHalt) ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == StHalt);
  end

  // Opcode bit 0 picks the memory operand, bit 1 picks subtraction.
  always_comb begin
    operand_a = op_q[0] ? mem_rdata : y_q;
    alu_res   = op_q[1] ? (operand_a - x_q) : (operand_a + x_q);
  end

  always_comb begin
    pc_d   = pc_q;
    op_d   = op_q;
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    r_d    = r_q;
    zero_d = zero_q;
    mem_we = 1'b0;
    case (state_q)
      StLoad: begin
        {op_d, addr_d, x_d, y_d} = instr_data;
        pc_d = pc_q + PC_W'(1);
      end
      StWb: begin
        if (!op_q[2]) begin
          r_d    = alu_res;
          zero_d = (alu_res == '0);
        end else begin
          case (op_q)
            OpStore: mem_we = 1'b1;
            OpJz:    if (zero_q) pc_d = x_q[PC_W-1:0];
            OpJmp:   pc_d = x_q[PC_W-1:0];
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      op_q   <= '0;
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      r_q    <= '0;
      zero_q <= 1'b1;
    end else begin
      pc_q   <= pc_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
      r_q    <= r_d;
      zero_q <= zero_d;
    end
  end

  // Data RAM is not reset; a write racing a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[addr_q] <= r_q;
    end
    if (state_q == StExec) begin
      mem_rdata <= mem[addr_q];
    end
  end

`ifdef NIBBLE_RETIRE_COUNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state_q == StWb) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired = retired_q;
`endif

  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign op         = op_q;
  assign addr       = addr_q;
  assign x          = x_q;
  assign y          = y_q;
  assign r          = r_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_nibble_core_p.sv
// Directed bench for nibble_core_p with a synchronous ROM model and hand-computed expectations.
// Retired-count checks are active when NIBBLE_RETIRE_COUNT_EN is defined.
module tb_nibble_core_p;

  logic        clk;
  logic        reset;
  logic        run;
  logic [23:0] instr_data;
  logic [4:0]  instr_addr;
  logic [4:0]  pc;
  logic [2:0]  op;
  logic [4:0]  addr;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  r;
  logic        zero;
  logic        halted;
`ifdef NIBBLE_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  logic [23:0] rom [32];
  int vectors = 0;
  int miscompares = 0;

  nibble_core_p dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .pc         (pc),
    .op         (op),
    .addr       (addr),
    .x          (x),
    .y          (y),
    .r          (r),
    .zero       (zero),
    .halted     (halted)
`ifdef NIBBLE_RETIRE_COUNT_EN
    ,
    .retired    (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  function automatic logic [23:0] enc(input logic [2:0] o, input logic [4:0] a,
                                      input logic [7:0] xv, input logic [7:0] yv);
    return {o, a, xv, yv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run_v);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
`ifdef NIBBLE_RETIRE_COUNT_EN
    chk("rst_retired", 32'(retired), 32'd0);
`endif
    reset = 1'b0;
    run   = run_v;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = enc(3'd7, 5'd0, 8'd0, 8'd0);

    // ADD, SUB to zero, taken JZ, ADD, untaken JZ
    rom[0] = enc(3'd0, 5'd0, 8'd3, 8'd5);
    rom[1] = enc(3'd2, 5'd0, 8'd8, 8'd8);
    rom[2] = enc(3'd5, 5'd0, 8'd6, 8'd0);
    rom[6] = enc(3'd0, 5'd0, 8'd1, 8'd1);
    rom[7] = enc(3'd5, 5'd0, 8'd20, 8'd0);
    do_reset(1'b1);
    cyc(4);
    chk("add_r", 32'(r), 32'd8);
    chk("add_zero", 32'(zero), 32'd0);
    chk("add_pc", 32'(pc), 32'd1);
    chk("add_x", 32'(x), 32'd3);
    chk("add_y", 32'(y), 32'd5);
    cyc(4);
    chk("sub_r", 32'(r), 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_pc", 32'(pc), 32'd2);
    cyc(4);
    chk("jz_pc", 32'(pc), 32'd6);
    chk("jz_zero", 32'(zero), 32'd1);
    cyc(4);
    chk("add2_r", 32'(r), 32'd2);
    chk("add2_pc", 32'(pc), 32'd7);
    cyc(4);
    chk("jzn_pc", 32'(pc), 32'd8);
    chk("jzn_zero", 32'(zero), 32'd0);

    // SUB 8-1 leaves r nonzero, JZ at 2 falls through to 3
    rom[1] = enc(3'd2, 5'd0, 8'd1, 8'd8);
    do_reset(1'b1);
    cyc(8);
    chk("sub7_r", 32'(r), 32'd7);
    cyc(4);
    chk("jz_nt_pc", 32'(pc), 32'd3);

    // Stall, memory ops, JMP, HALT
    rom[0] = enc(3'd0, 5'd0, 8'd10, 8'd0);
    rom[1] = enc(3'd4, 5'd2, 8'd0, 8'd0);
    rom[2] = enc(3'd1, 5'd2, 8'd1, 8'd0);
    rom[3] = enc(3'd3, 5'd2, 8'd11, 8'd0);
    rom[4] = enc(3'd6, 5'd0, 8'd5, 8'd0);
    rom[5] = enc(3'd7, 5'd0, 8'd0, 8'd0);
    do_reset(1'b0);
    cyc(10);
    chk("stall_pc", 32'(pc), 32'd0);
    chk("stall_r", 32'(r), 32'd0);
    chk("stall_x", 32'(x), 32'd0);
    run = 1'b1;
    cyc(1);
    run = 1'b0;
    cyc(3);
    chk("midrun_r", 32'(r), 32'd10);
    chk("midrun_pc", 32'(pc), 32'd1);
    cyc(8);
    chk("stall2_pc", 32'(pc), 32'd1);
    chk("stall2_op", 32'(op), 32'd0);
    run = 1'b1;
    cyc(4);
    chk("store_r", 32'(r), 32'd10);
    chk("store_zero", 32'(zero), 32'd0);
    chk("store_pc", 32'(pc), 32'd2);
    cyc(4);
    chk("addm_r", 32'(r), 32'd11);
    cyc(4);
    chk("subm_r", 32'(r), 32'd255);
    chk("subm_zero", 32'(zero), 32'd0);
    cyc(4);
    chk("jmp_pc", 32'(pc), 32'd5);
    cyc(4);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd6);
    chk("halt_op", 32'(op), 32'd7);
`ifdef NIBBLE_RETIRE_COUNT_EN
    chk("halt_retired", 32'(retired), 32'd6);
`endif
    run = 1'b0;
    cyc(10);
    run = 1'b1;
    cyc(10);
    chk("frz_halted", 32'(halted), 32'd1);
    chk("frz_pc", 32'(pc), 32'd6);
    chk("frz_r", 32'(r), 32'd255);
    chk("frz_zero", 32'(zero), 32'd0);
`ifdef NIBBLE_RETIRE_COUNT_EN
    chk("frz_retired", 32'(retired), 32'd6);
`endif

    // JMP to the top of program space, then the ADD there wraps pc to 0
    rom[0]  = enc(3'd6, 5'd0, 8'd31, 8'd0);
    rom[31] = enc(3'd0, 5'd0, 8'd4, 8'd0);
    do_reset(1'b1);
    cyc(4);
    chk("jmp31_pc", 32'(pc), 32'd31);
    cyc(4);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_r", 32'(r), 32'd4);

    // Reset during EXEC of a STORE must not write mem[2] (holds 10)
    rom[0] = enc(3'd0, 5'd0, 8'd99, 8'd0);
    rom[1] = enc(3'd4, 5'd2, 8'd0, 8'd0);
    do_reset(1'b1);
    cyc(4);
    chk("pre_r", 32'(r), 32'd99);
    cyc(2);
    chk("exec_op", 32'(op), 32'd4);
    reset = 1'b1;
    #1;
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_op", 32'(op), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_x", 32'(x), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_halted", 32'(halted), 32'd0);
    run = 1'b0;
    rom[0] = enc(3'd1, 5'd2, 8'd0, 8'd0);
    cyc(3);
    do_reset(1'b1);
    cyc(4);
    chk("mem_kept", 32'(r), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
